// File: rtl/game_pkg.sv
// game_pkg: shared speed-level constants and the rising-edges-per-step table.
package game_pkg;
    localparam int SPEED_W = 2;
    localparam int DIV_W = 3;
    localparam int CNT_W = 2;
    // Index by speed level; level 0 is the slowest (4 rising edges per step).
    localparam logic [3:0][DIV_W-1:0] DIV_TABLE = {3'd1, 3'd2, 3'd3, 3'd4};
    function automatic logic [DIV_W-1:0] step_div(input logic [SPEED_W-1:0] lvl);
        return DIV_TABLE[lvl];
    endfunction
endpackage

// File: rtl/game_tick_receiver_if.sv
// game_tick_receiver_if: step request/acknowledge handshake plus speed and pause controls.
interface game_tick_receiver_if;
    import game_pkg::*;
    logic [SPEED_W-1:0] speed_lvl;
    logic pause;
    logic step_req;
    logic step_ack;
    modport master(input speed_lvl, input pause, input step_ack, output step_req);
    modport slave(output speed_lvl, output pause, output step_ack, input step_req);
endinterface

// File: rtl/game_tick_receiver_sync_edge_det.sv
// sync_edge_det: synchronises the slow clock and flags its rising and any edges.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_ht,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic any_edge
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk_ht)
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    assign rise = sync[SYNC_STAGES-1] & ~prev;
    assign any_edge = sync[SYNC_STAGES-1] ^ prev;
endmodule

// File: rtl/game_tick_receiver.sv
// game_tick_receiver: turns slow-clock rising edges into speed-scaled step requests,
// with a clock-loss watchdog and a saturating count of steps the consumer missed.
module game_tick_receiver
    import game_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 80000000,
    parameter int OVR_W = 4
) (
    input  logic clk_ht,
    input  logic rst,
    input  logic clk_slow_in,
    game_tick_receiver_if.master ctl,
    output logic edge_pulse,
    output logic clk_lost,
    output logic [OVR_W-1:0] overrun_cnt
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic rise, any_edge, step_evt, ack, advance;
    logic [CNT_W-1:0] edge_cnt;
    logic [WD_W-1:0] wd_cnt;
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_ht(clk_ht),
        .rst(rst),
        .din(clk_slow_in),
        .rise(rise),
        .any_edge(any_edge)
    );
    // >= rather than == so a speed increase mid-count fires on the next edge.
    always_comb begin
        advance = rise & ~ctl.pause;
        step_evt = advance & (({1'b0, edge_cnt} + 3'd1) >= step_div(ctl.speed_lvl));
        ack = ctl.step_ack & ctl.step_req;
    end
    always_ff @(posedge clk_ht)
        if (rst) begin
            edge_cnt <= '0;
            wd_cnt <= '0;
            ctl.step_req <= 1'b0;
            edge_pulse <= 1'b0;
            clk_lost <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            edge_pulse <= rise;
            edge_cnt <= step_evt ? '0 : advance ? edge_cnt + 1'b1 : edge_cnt;
            ctl.step_req <= step_evt | (ctl.step_req & ~ack);
            if (step_evt & ctl.step_req & ~ack & ~&overrun_cnt)
                overrun_cnt <= overrun_cnt + 1'b1;
            wd_cnt <= any_edge ? '0 : (wd_cnt == WD_W'(TIMEOUT_CYC)) ? wd_cnt : wd_cnt + 1'b1;
            clk_lost <= any_edge ? 1'b0 : clk_lost | (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
        end
endmodule

// File: tb/tb_game_tick_receiver.sv
// tb_game_tick_receiver: directed scenarios plus a randomized run, every cycle checked
// against a sample-history reference model of the step receiver.
module tb_game_tick_receiver;
    localparam int S = 2;
    localparam int TO = 50;
    localparam int OW = 4;
    localparam int HALF = 10;
    localparam int OVR_MAX = (1 << OW) - 1;

    logic clk_ht = 1'b0;
    logic rst = 1'b1;
    logic clk_slow_in = 1'b0;
    logic edge_pulse, clk_lost;
    logic [OW-1:0] overrun_cnt;

    game_tick_receiver_if ctl();

    game_tick_receiver #(.SYNC_STAGES(S), .TIMEOUT_CYC(TO), .OVR_W(OW)) dut (
        .clk_ht(clk_ht),
        .rst(rst),
        .clk_slow_in(clk_slow_in),
        .ctl(ctl),
        .edge_pulse(edge_pulse),
        .clk_lost(clk_lost),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk_ht = ~clk_ht;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, rise_cyc = 0, slow_div = 0, last_edge = 0;
    int m_cnt = 0, m_ovr = 0;
    bit m_req = 0, m_pulse = 0, m_lost = 0;
    bit hold = 0, auto_ack = 0;
    // h[k] = clk_slow_in as sampled k clock edges ago
    bit h[1:S+1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        bit rise_now, any_now, ack_now, evt;
        if (auto_ack) ctl.step_ack = m_req;
        if (!hold) begin
            slow_div++;
            if (slow_div == HALF) begin
                slow_div = 0;
                clk_slow_in = ~clk_slow_in;
                if (clk_slow_in) rise_cyc = cyc + 1;
            end
        end
        @(posedge clk_ht);
        cyc++;
        if (rst) begin
            m_cnt = 0; m_req = 0; m_ovr = 0; m_pulse = 0; m_lost = 0;
            last_edge = cyc;
            for (int k = 1; k <= S + 1; k++) h[k] = 0;
        end else begin
            rise_now = h[S] & ~h[S+1];
            any_now = h[S] ^ h[S+1];
            ack_now = ctl.step_ack & m_req;
            evt = 0;
            if (rise_now && !ctl.pause) begin
                m_cnt++;
                if (m_cnt >= 4 - int'(ctl.speed_lvl)) begin
                    evt = 1;
                    m_cnt = 0;
                end
            end
            if (evt) begin
                if (m_req && !ack_now && m_ovr < OVR_MAX) m_ovr++;
                m_req = 1;
            end else if (ack_now) m_req = 0;
            m_pulse = rise_now;
            if (any_now) last_edge = cyc;
            m_lost = (cyc - last_edge) >= TO;
            for (int k = S + 1; k > 1; k--) h[k] = h[k-1];
            h[1] = clk_slow_in;
        end
        #1;
        check("edge_pulse", edge_pulse, m_pulse);
        check("step_req", ctl.step_req, m_req);
        check("clk_lost", clk_lost, m_lost);
        check("overrun_cnt", overrun_cnt, m_ovr);
    endtask

    task automatic run_pulses(input int n, output int reqs);
        int p;
        bit pr;
        p = 0;
        reqs = 0;
        for (int i = 0; i < n * 3 * HALF && p < n; i++) begin
            pr = ctl.step_req;
            tick();
            if (edge_pulse) p++;
            if (ctl.step_req && !pr) reqs++;
        end
        check("pulse_count", p, n);
    endtask

    task automatic do_reset();
        int i;
        for (i = 0; i < 4 * HALF && !(clk_slow_in == 0 && slow_div < 5); i++) tick();
        check("reset_window", i < 4 * HALF, 1);
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, v, i;
        ctl.speed_lvl = 2'd0;
        ctl.pause = 1'b0;
        ctl.step_ack = 1'b0;
        repeat (3) tick();
        check("rst_edge_pulse", edge_pulse, 0);
        check("rst_step_req", ctl.step_req, 0);
        rst = 0;

        // lvl 0 with prompt acks: a step every 4th pulse; lvl 3: every pulse
        auto_ack = 1;
        run_pulses(8, r);
        check("lvl0_steps", r, 2);
        ctl.speed_lvl = 2'd3;
        run_pulses(4, r);
        check("lvl3_steps", r, 4);
        ctl.speed_lvl = 2'd0;
        run_pulses(2, r);
        check("lvl0_two_edges", r, 0);
        ctl.speed_lvl = 2'd3;
        run_pulses(1, r);
        check("lvl_raise_fires", r, 1);

        // pause freezes the divider and leaves the pending request alone
        repeat (3) tick();
        auto_ack = 0;
        ctl.step_ack = 0;
        run_pulses(1, r);
        check("pending_req", ctl.step_req, 1);
        ctl.speed_lvl = 2'd0;
        run_pulses(1, r);
        v = overrun_cnt;
        ctl.pause = 1;
        run_pulses(5, r);
        check("pause_no_step", r, 0);
        check("pause_req_held", ctl.step_req, 1);
        check("pause_ovr_same", overrun_cnt, v);
        ctl.step_ack = 1;
        tick();
        ctl.step_ack = 0;
        check("ack_clears", ctl.step_req, 0);
        ctl.pause = 0;
        run_pulses(2, r);
        check("frozen_cnt_a", r, 0);
        run_pulses(1, r);
        check("frozen_cnt_b", r, 1);

        // ack in the same cycle as a new step: request stays, no overrun
        ctl.speed_lvl = 2'd3;
        for (i = 0; i < 4 * HALF && !(h[S] & ~h[S+1]); i++) tick();
        check("find_rise", i < 4 * HALF, 1);
        v = overrun_cnt;
        ctl.step_ack = 1;
        tick();
        ctl.step_ack = 0;
        check("coinc_req", ctl.step_req, 1);
        check("coinc_ovr", overrun_cnt, v);
        run_pulses(20, r);
        check("ovr_saturated", overrun_cnt, OVR_MAX);
        check("sat_req_held", ctl.step_req, 1);

        // reset while a request is pending and overruns have been counted
        do_reset();
        run_pulses(4, r);
        check("ovr_three", overrun_cnt, 3);
        do_reset();
        check("rst2_req", ctl.step_req, 0);
        check("rst2_ovr", overrun_cnt, 0);
        check("rst2_pulse", edge_pulse, 0);
        rise_cyc = -1000;
        for (i = 0; i < 6 * HALF && !edge_pulse; i++) tick();
        check("first_pulse_latency", cyc - rise_cyc, S);

        // slow clock held: loss flagged after TO cycles, cleared after next edge
        hold = 1;
        repeat (60) tick();
        check("clk_lost_set", clk_lost, 1);
        hold = 0;
        for (i = 0; i < 3 * HALF && clk_lost; i++) tick();
        check("clk_lost_cleared", clk_lost, 0);

        // stray acks while nothing is pending
        ctl.speed_lvl = 2'd0;
        ctl.step_ack = 1;
        for (i = 0; i < 10 && ctl.step_req; i++) tick();
        ctl.step_ack = 0;
        repeat (30) begin
            ctl.step_ack = m_req ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
        end

        // randomized run
        for (int c = 0; c < 900; c++) begin
            if (c % 40 == 0) begin
                ctl.speed_lvl = 2'($urandom_range(0, 3));
                ctl.pause = ($urandom_range(0, 5) == 0);
            end
            hold = (c >= 400 && c < 470);
            ctl.step_ack = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 0;
        hold = 0;
        ctl.step_ack = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
